// File: rtl/uart_bridge_pkg.sv
// Shared types and constants for the UART-driven bus initiator.
package uart_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_ADDR = 3'd1,
        ST_GET_DATA = 3'd2,
        ST_BUS_WR   = 3'd3,
        ST_BUS_RD   = 3'd4,
        ST_RD_WAIT  = 3'd5,
        ST_SEND     = 3'd6,
        ST_TX_WAIT  = 3'd7
    } state_e;

    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_BAD = 8'h3F;
    localparam logic [7:0] RSP_ERR = 8'h21;

    localparam int ADDR_BYTES = 4;
    localparam int DATA_BYTES = 4;

    // Single-byte response placed at the head of the transmit shift register.
    function automatic logic [31:0] rsp_word(input logic [7:0] b);
        return {b, 24'h000000};
    endfunction

endpackage

// File: rtl/uart_bus_bridge_if.sv
// UART-core and peripheral-bus signals seen by the bridge; master = bridge side.
interface uart_bus_bridge_if;
    logic [7:0]  rx_data;
    logic        rx_avail;
    logic        rx_error;
    logic        rx_ack;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_busy;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_rd;
    logic        bus_wr;
    logic [31:0] bus_rdata;
    logic        active;

    modport master (
        input  rx_data, rx_avail, rx_error, tx_busy, bus_rdata,
        output rx_ack, tx_data, tx_wr, bus_addr, bus_wdata, bus_rd, bus_wr, active
    );

    modport slave (
        output rx_data, rx_avail, rx_error, tx_busy, bus_rdata,
        input  rx_ack, tx_data, tx_wr, bus_addr, bus_wdata, bus_rd, bus_wr, active
    );
endinterface

// File: rtl/uart_bus_bridge.sv
// Bus initiator that parses 'W'/'R' command frames from a UART core and
// answers through its transmitter; all outputs are registered.
module uart_bus_bridge
    import uart_bridge_pkg::*;
#(
    parameter int RD_LAT      = 1,
    parameter int TIMEOUT_CYC = 250000
) (
    input logic            clk,
    input logic            rst,
    uart_bus_bridge_if.master br
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    state_e        state_r, state_nx_s;
    logic          take_s, launch_s, timeout_s, wait_s, getting_s;
    logic          armed_r, guard_r;
    logic          rx_ack_r, tx_wr_r, bus_rd_r, bus_wr_r, active_r;
    logic [7:0]    tx_data_r, cmd_r;
    logic [31:0]   addr_r, wdata_r, rsp_r;
    logic [2:0]    cnt_r, rsp_cnt_r;
    logic [TW-1:0] to_cnt_r;

    assign br.rx_ack    = rx_ack_r;
    assign br.tx_data   = tx_data_r;
    assign br.tx_wr     = tx_wr_r;
    assign br.bus_addr  = addr_r;
    assign br.bus_wdata = wdata_r;
    assign br.bus_rd    = bus_rd_r;
    assign br.bus_wr    = bus_wr_r;
    assign br.active    = active_r;

    // Next-state decode, byte acceptance and transmit launch.
    always_comb begin
        state_nx_s = state_r;
        launch_s   = 1'b0;
        getting_s  = (state_r == ST_GET_ADDR) || (state_r == ST_GET_DATA);
        wait_s     = (state_r == ST_IDLE) || getting_s;
        take_s     = wait_s && br.rx_avail && armed_r;
        timeout_s  = getting_s && !take_s && (to_cnt_r == TW'(TIMEOUT_CYC));
        case (state_r)
            ST_IDLE: begin
                if (take_s) begin
                    if (br.rx_error) begin
                        state_nx_s = ST_SEND;
                    end else if ((br.rx_data == CMD_WR) || (br.rx_data == CMD_RD)) begin
                        state_nx_s = ST_GET_ADDR;
                    end else begin
                        state_nx_s = ST_SEND;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_GET_ADDR: begin
                if (take_s) begin
                    if (br.rx_error) begin
                        state_nx_s = ST_SEND;
                    end else if (cnt_r == 3'(ADDR_BYTES - 1)) begin
                        state_nx_s = (cmd_r == CMD_WR) ? ST_GET_DATA : ST_BUS_RD;
                    end else begin
                        state_nx_s = ST_GET_ADDR;
                    end
                end else if (timeout_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_GET_ADDR;
                end
            end
            ST_GET_DATA: begin
                if (take_s) begin
                    if (br.rx_error) begin
                        state_nx_s = ST_SEND;
                    end else if (cnt_r == 3'(DATA_BYTES - 1)) begin
                        state_nx_s = ST_BUS_WR;
                    end else begin
                        state_nx_s = ST_GET_DATA;
                    end
                end else if (timeout_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_GET_DATA;
                end
            end
            ST_BUS_WR: state_nx_s = ST_SEND;
            ST_BUS_RD: state_nx_s = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (cnt_r == 3'(RD_LAT)) begin
                    state_nx_s = ST_SEND;
                end else begin
                    state_nx_s = ST_RD_WAIT;
                end
            end
            ST_SEND: begin
                if (!br.tx_busy) begin
                    launch_s   = 1'b1;
                    state_nx_s = ST_TX_WAIT;
                end else begin
                    state_nx_s = ST_SEND;
                end
            end
            ST_TX_WAIT: begin
                // First cycle carries tx_wr, second is the guard before re-checking tx_busy.
                if (guard_r) begin
                    state_nx_s = (rsp_cnt_r == 3'd0) ? ST_IDLE : ST_SEND;
                end else begin
                    state_nx_s = ST_TX_WAIT;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State register, registered outputs and frame datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            armed_r   <= 1'b1;
            guard_r   <= 1'b0;
            rx_ack_r  <= 1'b0;
            tx_wr_r   <= 1'b0;
            bus_rd_r  <= 1'b0;
            bus_wr_r  <= 1'b0;
            active_r  <= 1'b0;
            tx_data_r <= 8'h00;
            cmd_r     <= 8'h00;
            addr_r    <= 32'h0000_0000;
            wdata_r   <= 32'h0000_0000;
            rsp_r     <= 32'h0000_0000;
            cnt_r     <= 3'd0;
            rsp_cnt_r <= 3'd0;
            to_cnt_r  <= '0;
        end else begin
            state_r  <= state_nx_s;
            rx_ack_r <= take_s;
            // Re-arm only after rx_avail has been seen low, so a late-clearing flag is not re-read.
            armed_r  <= take_s ? 1'b0 : (armed_r | ~br.rx_avail);
            guard_r  <= (state_r == ST_TX_WAIT);
            tx_wr_r  <= launch_s;
            bus_wr_r <= (state_nx_s == ST_BUS_WR);
            bus_rd_r <= (state_nx_s == ST_BUS_RD);
            active_r <= (state_nx_s != ST_IDLE);
            to_cnt_r <= (getting_s && !take_s) ? (to_cnt_r + TW'(1)) : '0;
            case (state_r)
                ST_IDLE: begin
                    if (take_s) begin
                        cmd_r <= br.rx_data;
                        cnt_r <= 3'd0;
                        if (br.rx_error) begin
                            rsp_r     <= rsp_word(RSP_ERR);
                            rsp_cnt_r <= 3'd1;
                        end else begin
                            rsp_r     <= rsp_word(RSP_BAD);
                            rsp_cnt_r <= 3'd1;
                        end
                    end
                end
                ST_GET_ADDR, ST_GET_DATA: begin
                    if (take_s) begin
                        if (br.rx_error) begin
                            rsp_r     <= rsp_word(RSP_ERR);
                            rsp_cnt_r <= 3'd1;
                        end else begin
                            if (state_r == ST_GET_ADDR) begin
                                addr_r <= {addr_r[23:0], br.rx_data};
                            end else begin
                                wdata_r <= {wdata_r[23:0], br.rx_data};
                            end
                            cnt_r <= (cnt_r == 3'd3) ? 3'd0 : (cnt_r + 3'd1);
                        end
                    end
                end
                ST_BUS_WR: begin
                    rsp_r     <= rsp_word(RSP_OK);
                    rsp_cnt_r <= 3'd1;
                end
                ST_BUS_RD: cnt_r <= 3'd1;
                ST_RD_WAIT: begin
                    if (cnt_r == 3'(RD_LAT)) begin
                        rsp_r     <= br.bus_rdata;
                        rsp_cnt_r <= 3'd4;
                    end else begin
                        cnt_r <= cnt_r + 3'd1;
                    end
                end
                ST_SEND: begin
                    if (launch_s) begin
                        tx_data_r <= rsp_r[31:24];
                        rsp_r     <= {rsp_r[23:0], 8'h00};
                        rsp_cnt_r <= rsp_cnt_r - 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Directed frames against a transaction-level scoreboard of bus accesses and
// transmitted bytes, with a UART transmitter and registered-read responder model.
module tb_uart_bus_bridge;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_bus_bridge_if bif();

    uart_bus_bridge #(.RD_LAT(1), .TIMEOUT_CYC(100)) dut (
        .clk(clk),
        .rst(rst),
        .br(bif.master)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_wr_addr[$];
    logic [31:0] exp_wr_data[$];
    logic [31:0] exp_rd_addr[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  tx_log[$];
    int ack_seen = 0;
    int wr_seen  = 0;
    int rd_seen  = 0;

    int          busy_cnt = 0;
    logic [31:0] rdata_r  = 32'hDEAD_BEEF;

    assign bif.tx_busy   = (busy_cnt != 0);
    assign bif.bus_rdata = rdata_r;

    function automatic logic [31:0] rd_value(input logic [31:0] a);
        if (a == 32'h0000_0008) return 32'h0000_00A5;
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        total++;
        bad++;
        $display("FAIL %s: event occurred, none expected", name);
    endtask

    // UART transmitter: busy for several cycles after each tx_wr.
    always @(posedge clk) begin
        if (rst) busy_cnt <= 0;
        else if (bif.tx_wr) busy_cnt <= 6;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end

    // Responder: data valid exactly one cycle after the read strobe.
    always @(posedge clk) begin
        if (bif.bus_rd) rdata_r <= rd_value(bif.bus_addr);
        else rdata_r <= 32'hDEAD_BEEF;
    end

    // Scoreboard compare on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bif.rx_ack) ack_seen++;
            if (bif.bus_wr && bif.bus_rd) unexpected("strobe_overlap");
            if (bif.bus_wr) begin
                wr_seen++;
                if (exp_wr_addr.size() == 0) unexpected("bus_wr");
                else begin
                    chk("wr_addr", bif.bus_addr, exp_wr_addr.pop_front());
                    chk("wr_data", bif.bus_wdata, exp_wr_data.pop_front());
                end
            end
            if (bif.bus_rd) begin
                rd_seen++;
                if (exp_rd_addr.size() == 0) unexpected("bus_rd");
                else chk("rd_addr", bif.bus_addr, exp_rd_addr.pop_front());
            end
            if (bif.tx_wr) begin
                tx_log.push_back(bif.tx_data);
                chk("tx_idle_at_launch", {31'd0, bif.tx_busy}, 32'd0);
                if (exp_tx.size() == 0) unexpected("tx_wr");
                else chk("tx_data", {24'd0, bif.tx_data}, {24'd0, exp_tx.pop_front()});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic err, input int hold);
        bit got;
        got = 1'b0;
        @(negedge clk);
        bif.rx_data  = b;
        bif.rx_error = err;
        bif.rx_avail = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bif.rx_ack) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) unexpected("rx_ack_timeout");
        repeat (hold) @(negedge clk);
        bif.rx_avail = 1'b0;
        bif.rx_error = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], 1'b0, 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_tx.size() != 0 || exp_wr_addr.size() != 0 || exp_rd_addr.size() != 0
                || bif.active) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) unexpected("drain_timeout");
        repeat (3) @(negedge clk);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        exp_wr_addr.push_back(a);
        exp_wr_data.push_back(d);
        exp_tx.push_back(8'h4B);
        send_byte(8'h57, 1'b0, 0);
        send_word(a);
        send_word(d);
        drain();
    endtask

    task automatic expect_read(input logic [31:0] a);
        logic [31:0] v;
        v = rd_value(a);
        exp_rd_addr.push_back(a);
        for (int i = 3; i >= 0; i--) exp_tx.push_back(v[8*i +: 8]);
    endtask

    int a0, n0, w0, r0;

    initial begin
        bif.rx_data  = 8'h00;
        bif.rx_avail = 1'b0;
        bif.rx_error = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx_wr", {31'd0, bif.tx_wr}, 32'd0);
        chk("rst_active", {31'd0, bif.active}, 32'd0);
        chk("rst_bus_addr", bif.bus_addr, 32'd0);
        chk("rst_rx_ack", {31'd0, bif.rx_ack}, 32'd0);
        rst = 1'b0;

        // Write frame
        a0 = ack_seen;
        n0 = tx_log.size();
        do_write(32'h0000_0010, 32'h0000_0007);
        chk("write_acks", ack_seen - a0, 9);
        chk("write_rsp", {24'd0, tx_log[n0]}, 32'h4B);
        chk("write_rsp_count", tx_log.size() - n0, 1);

        // Read frame, address 8 returns 0xA5
        n0 = tx_log.size();
        expect_read(32'h0000_0008);
        send_byte(8'h52, 1'b0, 0);
        send_word(32'h0000_0008);
        drain();
        chk("read_b0", {24'd0, tx_log[n0]},   32'h00);
        chk("read_b1", {24'd0, tx_log[n0+1]}, 32'h00);
        chk("read_b2", {24'd0, tx_log[n0+2]}, 32'h00);
        chk("read_b3", {24'd0, tx_log[n0+3]}, 32'hA5);

        // Unknown command then a good read
        n0 = tx_log.size();
        w0 = wr_seen;
        r0 = rd_seen;
        exp_tx.push_back(8'h3F);
        send_byte(8'h41, 1'b0, 0);
        drain();
        chk("unknown_rsp", {24'd0, tx_log[n0]}, 32'h3F);
        chk("unknown_no_strobe", wr_seen + rd_seen, w0 + r0);
        expect_read(32'h0000_1234);
        send_byte(8'h52, 1'b0, 0);
        send_word(32'h0000_1234);
        drain();

        // Timeout mid-frame
        n0 = tx_log.size();
        w0 = wr_seen;
        r0 = rd_seen;
        send_byte(8'h57, 1'b0, 0);
        send_byte(8'h00, 1'b0, 0);
        send_byte(8'h00, 1'b0, 0);
        repeat (50) @(negedge clk);
        chk("timeout_active_mid", {31'd0, bif.active}, 32'd1);
        repeat (60) @(negedge clk);
        chk("timeout_active_drop", {31'd0, bif.active}, 32'd0);
        chk("timeout_no_tx", tx_log.size(), n0);
        chk("timeout_no_strobe", wr_seen + rd_seen, w0 + r0);
        do_write(32'h0000_0020, 32'hCAFE_F00D);

        // rx_error on third address byte
        n0 = tx_log.size();
        w0 = wr_seen;
        r0 = rd_seen;
        exp_tx.push_back(8'h21);
        send_byte(8'h52, 1'b0, 0);
        send_byte(8'h00, 1'b0, 0);
        send_byte(8'h00, 1'b0, 0);
        send_byte(8'h00, 1'b1, 0);
        drain();
        chk("err_rsp", {24'd0, tx_log[n0]}, 32'h21);
        chk("err_no_strobe", wr_seen + rd_seen, w0 + r0);

        // rx_avail held high after ack consumes one byte
        a0 = ack_seen;
        expect_read(32'h0000_0008);
        send_byte(8'h52, 1'b0, 3);
        chk("hold_single_ack", ack_seen - a0, 1);
        send_word(32'h0000_0008);
        drain();

        // Reset during the second read-response byte
        n0 = tx_log.size();
        expect_read(32'h0000_0100);
        send_byte(8'h52, 1'b0, 0);
        send_word(32'h0000_0100);
        for (int i = 0; i < 3000 && tx_log.size() < n0 + 2; i++) @(negedge clk);
        chk("rst_mid_reached", tx_log.size(), n0 + 2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rstmid_tx_wr", {31'd0, bif.tx_wr}, 32'd0);
        chk("rstmid_active", {31'd0, bif.active}, 32'd0);
        chk("rstmid_tx_data", {24'd0, bif.tx_data}, 32'd0);
        chk("rstmid_bus_addr", bif.bus_addr, 32'd0);
        chk("rstmid_strobes", {30'd0, bif.bus_rd, bif.bus_wr}, 32'd0);
        exp_tx.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("rstmid_no_more_tx", tx_log.size(), n0 + 2);
        do_write(32'h8000_0004, 32'h1234_5678);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
